// File: rtl/sqrt_host_driver.sv
// Host-side sequencer for an fp16 sqrt core on a shared bidirectional bus.
// Define SQRT_HOST_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT_CYCLES.
module sqrt_host_driver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [15:0] REQ_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_DATA,
    output logic        RSP_NAN,
    output logic        RSP_PINF,
    output logic        RSP_NINF,
    output logic        RSP_TIMEOUT,
    output logic [7:0]  RSP_CYCLES,
    inout  wire  [15:0] IO_DATA,
    output logic        ENABLE,
    input  logic        RESULT,
    input  logic        IS_NAN,
    input  logic        IS_PINF,
    input  logic        IS_NINF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        capture;
    logic        expire;
    logic        drive_en;
    logic [15:0] operand;
    logic [7:0]  cycle_cnt;
    logic [7:0]  cycles_next;

    // The bus is ours only for the single LOAD cycle.
    assign IO_DATA = drive_en ? operand : {16{1'bz}};

    assign cycles_next = (cycle_cnt == 8'hFF) ? 8'hFF : cycle_cnt + 8'd1;

`ifdef SQRT_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    // TIMEOUT_CYCLES has no effect unless the timeout build is selected.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end

    assign RSP_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    accept     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = WAIT;
            end
            WAIT: begin
                // A result landing on the final timeout cycle still wins.
                if (RESULT) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
`ifdef SQRT_HOST_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    expire     = 1'b1;
                    next_state = RESP;
                end
`endif
            end
            RESP: begin
                if (RSP_VALID && RSP_READY) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs derive from next_state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            REQ_READY  <= 1'b0;
            ENABLE     <= 1'b0;
            drive_en   <= 1'b0;
            operand    <= 16'h0000;
            cycle_cnt  <= 8'd0;
            RSP_VALID  <= 1'b0;
            RSP_DATA   <= 16'h0000;
            RSP_NAN    <= 1'b0;
            RSP_PINF   <= 1'b0;
            RSP_NINF   <= 1'b0;
            RSP_CYCLES <= 8'd0;
`ifdef SQRT_HOST_TIMEOUT_EN
            RSP_TIMEOUT <= 1'b0;
`endif
        end else begin
            REQ_READY <= (next_state == IDLE);
            ENABLE    <= (next_state == LOAD) || (next_state == WAIT);
            drive_en  <= (next_state == LOAD);
            RSP_VALID <= (next_state == RESP);

            if (accept) begin
                operand   <= REQ_DATA;
                cycle_cnt <= 8'd0;
            end else if (state == WAIT) begin
                cycle_cnt <= cycles_next;
            end

            if (capture) begin
                RSP_DATA   <= IO_DATA;
                RSP_NAN    <= IS_NAN;
                RSP_PINF   <= IS_PINF;
                RSP_NINF   <= IS_NINF;
                RSP_CYCLES <= cycles_next;
`ifdef SQRT_HOST_TIMEOUT_EN
                RSP_TIMEOUT <= 1'b0;
`endif
            end else if (expire) begin
                RSP_DATA   <= 16'h7E00;
                RSP_NAN    <= 1'b0;
                RSP_PINF   <= 1'b0;
                RSP_NINF   <= 1'b0;
                RSP_CYCLES <= cycles_next;
`ifdef SQRT_HOST_TIMEOUT_EN
                RSP_TIMEOUT <= 1'b1;
`endif
            end
        end
    end

endmodule
